codec_cfg_sequencer: RTL

Parametrised configuration sequencer for the audio codec's I2C control port. After a start pulse it walks a table of register writes defined in the package. Failed writes are retried up to a bound, and a settle delay is inserted after each write. Once initialised, it accepts manual register writes through a valid/ready handshake. It sits between the top level and the shared I2C write master, driving that master's transaction interface rather than the SDAT/SDCLK pins.

---
 rtl/codec_cfg_pkg.sv | 48 ++++
 rtl/codec_cfg_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared types and the default power-up register table for the audio codec control sequencer.
package codec_cfg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StSettle,
      StNext,
      StReady,
      StFail
   } state_e;

   localparam logic [3:0] I2C_ERR_NONE      = 4'd0;
   localparam logic [3:0] I2C_ERR_ADDR_NACK = 4'd1;
   localparam logic [3:0] I2C_ERR_REG_NACK  = 4'd2;
   localparam logic [3:0] I2C_ERR_DATA_NACK = 4'd3;

   localparam int unsigned CFG_LEN    = 6;
   localparam int unsigned CFG_IDX_W  = $clog2(CFG_LEN);
   localparam int unsigned CFG_REG_W  = 7;
   localparam int unsigned CFG_DATA_W = 9;

   // Power up partially, set format and paths, activate, then release full power.
   localparam logic [CFG_REG_W-1:0] CFG_REG [CFG_LEN] = '{
      7'h06, 7'h07, 7'h04, 7'h05, 7'h09, 7'h06
   };
   localparam logic [CFG_DATA_W-1:0] CFG_DATA [CFG_LEN] = '{
      9'h010, 9'h053, 9'h010, 9'h000, 9'h001, 9'h000
   };

   typedef struct packed {
      logic [CFG_REG_W-1:0]  reg_addr;
      logic [CFG_DATA_W-1:0] data;
   } cfg_entry_t;

   // Indices past the table return an all-zero write.
   function automatic cfg_entry_t cfg_entry(input int unsigned idx);
      cfg_entry_t e;
      e = '0;
      if (idx < CFG_LEN) begin
         e.reg_addr = CFG_REG[idx[CFG_IDX_W-1:0]];
         e.data     = CFG_DATA[idx[CFG_IDX_W-1:0]];
      end
      return e;
   endfunction

endpackage

// File: rtl/codec_cfg_sequencer.sv
// Walks the codec init table through the shared I2C write master with retries and settle
// gaps, then serves manual register writes over a valid/ready handshake.
module codec_cfg_sequencer
   import codec_cfg_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR      = 7'b0011010,
   parameter int unsigned REG_W         = 7,
   parameter int unsigned DATA_W        = 9,
   parameter int unsigned NUM_ENTRIES   = 6,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned SETTLE_CYCLES = 50,
   localparam int unsigned IDX_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic              CLOCK_50,
   input  logic              rst,
   input  logic              init_start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [REG_W-1:0]  cmd_reg,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              cmd_done,
   output logic [3:0]        cmd_err,
   output logic              init_done,
   output logic              init_fail,
   output logic [IDX_W-1:0]  fail_index,
   output logic [3:0]        fail_code,
   output logic              busy,
   output logic              i2c_start,
   output logic [6:0]        i2c_addr,
   output logic [REG_W-1:0]  i2c_reg,
   output logic [DATA_W-1:0] i2c_data,
   output logic              i2c_rw,
   input  logic              i2c_done,
   input  logic [3:0]        i2c_err
);

   localparam int unsigned RETRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);
   localparam logic [RETRY_W-1:0]  RETRY_MAX  = RETRY_W'(MAX_RETRIES);
   localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SETTLE_CYCLES);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [3:0]          err_q, err_d;
   logic                manual_q, manual_d;
   logic [REG_W-1:0]    reg_addr_q, reg_addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                init_done_q, init_done_d;
   logic                init_fail_q, init_fail_d;
   logic [IDX_W-1:0]    fail_index_q, fail_index_d;
   logic [3:0]          fail_code_q, fail_code_d;
   logic                cmd_done_q, cmd_done_d;
   logic [3:0]          cmd_err_q, cmd_err_d;
   logic                start_seq;
   logic                load_entry;
   cfg_entry_t          entry;

   assign start_seq = init_start && (state_q inside {StIdle, StReady, StFail});

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      retry_d      = retry_q;
      settle_d     = settle_q;
      err_d        = err_q;
      manual_d     = manual_q;
      reg_addr_d   = reg_addr_q;
      data_d       = data_q;
      init_done_d  = init_done_q;
      init_fail_d  = init_fail_q;
      fail_index_d = fail_index_q;
      fail_code_d  = fail_code_q;
      cmd_done_d   = 1'b0;
      cmd_err_d    = cmd_err_q;
      load_entry   = 1'b0;
      entry        = '0;

      if (start_seq) begin
         idx_d       = '0;
         retry_d     = '0;
         manual_d    = 1'b0;
         init_done_d = 1'b0;
         init_fail_d = 1'b0;
         load_entry  = 1'b1;
         state_d     = StIssue;
      end else begin
         unique case (state_q)
            StIdle: ;
            StIssue: state_d = StWait;
            StWait: begin
               if (i2c_done) begin
                  err_d = i2c_err;
                  if (SETTLE_CYCLES == 0) begin
                     state_d = StNext;
                  end else begin
                     settle_d = SETTLE_W'(1);
                     state_d  = StSettle;
                  end
               end
            end
            StSettle: begin
               if (settle_q == SETTLE_END) state_d = StNext;
               else                        settle_d = settle_q + 1'b1;
            end
            StNext: begin
               if (err_q != I2C_ERR_NONE && retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = StIssue;
               end else if (err_q != I2C_ERR_NONE) begin
                  if (manual_q) begin
                     cmd_done_d = 1'b1;
                     cmd_err_d  = err_q;
                     state_d    = StReady;
                  end else begin
                     init_fail_d  = 1'b1;
                     fail_index_d = idx_q;
                     fail_code_d  = err_q;
                     state_d      = StFail;
                  end
               end else if (manual_q) begin
                  cmd_done_d = 1'b1;
                  cmd_err_d  = I2C_ERR_NONE;
                  state_d    = StReady;
               end else if (idx_q == LAST_IDX) begin
                  init_done_d = 1'b1;
                  state_d     = StReady;
               end else begin
                  idx_d      = idx_q + 1'b1;
                  retry_d    = '0;
                  load_entry = 1'b1;
                  state_d    = StIssue;
               end
            end
            StReady: begin
               if (cmd_valid) begin
                  reg_addr_d = cmd_reg;
                  data_d     = cmd_data;
                  retry_d    = '0;
                  manual_d   = 1'b1;
                  state_d    = StIssue;
               end
            end
            StFail: ;
            default: state_d = StIdle;
         endcase
      end

      if (load_entry) begin
         entry      = cfg_entry(32'(idx_d));
         reg_addr_d = REG_W'(entry.reg_addr);
         data_d     = DATA_W'(entry.data);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         retry_q      <= '0;
         settle_q     <= '0;
         err_q        <= '0;
         manual_q     <= 1'b0;
         reg_addr_q   <= '0;
         data_q       <= '0;
         init_done_q  <= 1'b0;
         init_fail_q  <= 1'b0;
         fail_index_q <= '0;
         fail_code_q  <= '0;
         cmd_done_q   <= 1'b0;
         cmd_err_q    <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         retry_q      <= retry_d;
         settle_q     <= settle_d;
         err_q        <= err_d;
         manual_q     <= manual_d;
         reg_addr_q   <= reg_addr_d;
         data_q       <= data_d;
         init_done_q  <= init_done_d;
         init_fail_q  <= init_fail_d;
         fail_index_q <= fail_index_d;
         fail_code_q  <= fail_code_d;
         cmd_done_q   <= cmd_done_d;
         cmd_err_q    <= cmd_err_d;
      end
   end

   assign cmd_ready  = (state_q == StReady) && !init_start;
   assign busy       = !(state_q inside {StIdle, StReady, StFail});
   assign i2c_start  = (state_q == StIssue);
   assign i2c_addr   = DEV_ADDR;
   assign i2c_rw     = 1'b0;
   assign i2c_reg    = reg_addr_q;
   assign i2c_data   = data_q;
   assign cmd_done   = cmd_done_q;
   assign cmd_err    = cmd_err_q;
   assign init_done  = init_done_q;
   assign init_fail  = init_fail_q;
   assign fail_index = fail_index_q;
   assign fail_code  = fail_code_q;

endmodule
